// File: rtl/bsg_manycore_ver_mem_responder.sv
// Vertical-link memory endpoint standing in for a vcache bank: services remote load/store
// packets from the fwd network against a local word memory and answers on the rev network.

module bsg_manycore_ver_mem_responder
    #(parameter int addr_width_p     = 12
    , parameter int data_width_p     = 32
    , parameter int x_cord_width_p   = 4
    , parameter int y_cord_width_p   = 4
    , parameter int mem_els_p        = 1024
    , parameter int fifo_els_p       = 2
    , localparam int mask_width_lp   = data_width_p/8
    , localparam int fwd_pkt_width_lp = addr_width_p + 2 + mask_width_lp + 5 + data_width_p
                                        + 2*(x_cord_width_p + y_cord_width_p)
    , localparam int rev_pkt_width_lp = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p
    , localparam int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 4)
    (input  logic                         clk_i
    , input  logic                         reset_i
    , input  logic [link_sif_width_lp-1:0] link_sif_i
    , output logic [link_sif_width_lp-1:0] link_sif_o
    , output logic [15:0]                  err_cnt_o
    );

    localparam int lg_mem_els_lp     = $clog2(mem_els_p);
    localparam int fifo_ptr_width_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int fifo_cnt_width_lp = $clog2(fifo_els_p + 1);

    typedef enum logic [1:0] {e_remote_load = 2'd0, e_remote_store = 2'd1} remote_op_e;
    typedef enum logic [1:0] {e_return_credit = 2'd0, e_return_int_wb = 2'd1} return_type_e;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [1:0]                op;
        logic [mask_width_lp-1:0]  op_ex;
        logic [4:0]                reg_id;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y;
        logic [x_cord_width_p-1:0] src_x;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } fwd_pkt_s;

    typedef struct packed {
        return_type_e              pkt_type;
        logic [data_width_p-1:0]   data;
        logic [4:0]                reg_id;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } rev_pkt_s;

    typedef struct packed {logic v; fwd_pkt_s data; logic ready_and;} fwd_ch_s;
    typedef struct packed {logic v; rev_pkt_s data; logic ready_and;} rev_ch_s;
    typedef struct packed {fwd_ch_s fwd; rev_ch_s rev;} link_sif_s;

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // Fwd input FIFO
    fwd_pkt_s                     fifo_mem [fifo_els_p];
    logic [fifo_ptr_width_lp-1:0] wptr_q, rptr_q;
    logic [fifo_cnt_width_lp-1:0] count_q;
    logic                         full, empty, fwd_ready, enq, pop;

    logic                         resp_v_q;
    rev_pkt_s                     resp_q;
    logic [15:0]                  err_cnt_q;

    function automatic logic [fifo_ptr_width_lp-1:0] ptr_inc(input logic [fifo_ptr_width_lp-1:0] p);
        return (p == fifo_ptr_width_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == fifo_cnt_width_lp'(fifo_els_p));
    assign empty     = (count_q == '0);
    assign fwd_ready = ~full & ~reset_i;
    assign enq       = link_in.fwd.v & fwd_ready;
    // The response slot frees up in the same edge it is accepted, so issue never bubbles.
    assign pop       = ~empty & (~resp_v_q | link_in.rev.ready_and);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) wptr_q <= ptr_inc(wptr_q);
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({enq, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; pointers and valid state alone define occupancy.
    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem[wptr_q] <= link_in.fwd.data;
    end

    // Issue stage
    fwd_pkt_s                 head;
    logic [lg_mem_els_lp-1:0] idx;
    logic                     in_range, is_load, is_store;
    logic [mask_width_lp-1:0] wr_mask;

    assign head     = fifo_mem[rptr_q];
    assign idx      = head.addr[lg_mem_els_lp-1:0];
    assign is_load  = (head.op == e_remote_load);
    assign is_store = (head.op == e_remote_store);
    assign wr_mask  = (is_store & in_range) ? head.op_ex : '0;

    if (addr_width_p > lg_mem_els_lp) begin : g_range
        assign in_range = ~|head.addr[addr_width_p-1:lg_mem_els_lp];
    end else begin : g_full_range
        assign in_range = 1'b1;
    end

    logic [data_width_p-1:0] mem [mem_els_p];

    always_ff @(posedge clk_i) begin
        if (pop) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (wr_mask[b]) mem[idx][8*b +: 8] <= head.payload[8*b +: 8];
            end
        end
    end

    // Response register captures the read word, so a stalled response stays intact.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_v_q  <= 1'b0;
            resp_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pop) begin
                resp_v_q        <= 1'b1;
                resp_q.pkt_type <= is_load ? e_return_int_wb : e_return_credit;
                resp_q.data     <= (is_load & in_range) ? mem[idx] : '0;
                resp_q.reg_id   <= head.reg_id;
                resp_q.y_cord   <= head.src_y;
                resp_q.x_cord   <= head.src_x;
            end else if (link_in.rev.ready_and) begin
                resp_v_q <= 1'b0;
            end
            if (pop & ~in_range & (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    // NOTE: default the whole struct first so no field can hold its value as a latch.
    always_comb begin
        link_out               = '0;
        link_out.fwd.ready_and = fwd_ready;
        link_out.rev.v         = resp_v_q;
        link_out.rev.data      = resp_q;
    end

    assign err_cnt_o = err_cnt_q;

    logic unused_fields;
    assign unused_fields = ^{link_in.fwd.ready_and, link_in.rev.v, link_in.rev.data,
                             head.y_cord, head.x_cord};

endmodule

// File: tb/tb_bsg_manycore_ver_mem_responder.sv
// Self-checking bench: directed vector table, hand sequences for backpressure/stream/reset,
// and randomized traffic scored against an in-order memory model.

module tb_bsg_manycore_ver_mem_responder;

    typedef struct packed {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [3:0]  op_ex;
        logic [4:0]  reg_id;
        logic [31:0] payload;
        logic [3:0]  src_y;
        logic [3:0]  src_x;
        logic [3:0]  y_cord;
        logic [3:0]  x_cord;
    } fwd_pkt_t;

    typedef struct packed {
        logic [1:0]  pkt_type;
        logic [31:0] data;
        logic [4:0]  reg_id;
        logic [3:0]  y_cord;
        logic [3:0]  x_cord;
    } rev_pkt_t;

    typedef struct packed {
        logic     fwd_v;
        fwd_pkt_t fwd_data;
        logic     fwd_ready_and;
        logic     rev_v;
        rev_pkt_t rev_data;
        logic     rev_ready_and;
    } link_t;

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] data;
        logic [31:0] kmask;
        logic [4:0]  reg_id;
        logic [3:0]  y;
        logic [3:0]  x;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [4:0]  reg_id;
        logic [1:0]  exp_type;
        logic [31:0] exp_data;
        logic [15:0] exp_err;
    } vec_t;

    localparam logic [1:0] OP_LD = 2'd0, OP_ST = 2'd1;
    localparam logic [1:0] T_CREDIT = 2'd0, T_WB = 2'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fwd_v = 1'b0;
    fwd_pkt_t    fwd_pkt = '0;
    logic        rev_ready;
    int          bp_mode = 0;  // 0 always ready, 1 never ready, 2 random
    link_t       lin, lout;
    logic [15:0] err_cnt;

    int checks = 0, errors = 0;
    int cyc = 0, resp_cnt = 0;
    int acc_cyc_q[$], resp_cyc_q[$];
    exp_t exp_q[$];
    rev_pkt_t last_resp;
    logic [31:0] mmem [1024];
    logic [3:0]  mknown [1024];
    logic [15:0] model_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rev_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
    initial rev_ready = 1'b1;

    always_comb begin
        lin               = '0;
        lin.fwd_v         = fwd_v;
        lin.fwd_data      = fwd_pkt;
        lin.rev_ready_and = rev_ready;
    end

    bsg_manycore_ver_mem_responder #(
        .addr_width_p(12), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
        .mem_els_p(1024), .fifo_els_p(2)
    ) dut (
        .clk_i(clk), .reset_i(reset), .link_sif_i(lin), .link_sif_o(lout), .err_cnt_o(err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Reference model: requests take effect in arrival order, so the expected reply is known at accept.
    task automatic model_accept(input fwd_pkt_t p);
        exp_t e;
        logic inr;
        logic [9:0] i;
        inr = (p.addr < 12'd1024);
        i = p.addr[9:0];
        e.reg_id = p.reg_id; e.y = p.src_y; e.x = p.src_x;
        e.kmask = '1; e.data = '0;
        if (!inr && model_err != 16'hFFFF) model_err = model_err + 1'b1;
        if (p.op == OP_LD) begin
            e.typ = T_WB;
            if (inr) begin
                e.data = mmem[i];
                e.kmask = expand(mknown[i]);
            end
        end else begin
            e.typ = T_CREDIT;
            if (p.op == OP_ST && inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (p.op_ex[b]) begin
                        mmem[i][8*b +: 8] = p.payload[8*b +: 8];
                        mknown[i][b] = 1'b1;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    logic        prev_stall = 1'b0;
    logic [47:0] prev_held;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {lout.rev_v, lout.rev_data}, prev_held);
            if (fwd_v && lout.fwd_ready_and) begin
                model_accept(fwd_pkt);
                acc_cyc_q.push_back(cyc);
            end
            if (lout.rev_v && rev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_resp: got response %h expected none", lout.rev_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_type", lout.rev_data.pkt_type, e.typ);
                    check("resp_data", lout.rev_data.data & e.kmask, e.data & e.kmask);
                    check("resp_dest", {lout.rev_data.reg_id, lout.rev_data.y_cord, lout.rev_data.x_cord},
                          {e.reg_id, e.y, e.x});
                end
                last_resp = lout.rev_data;
                resp_cnt++;
                resp_cyc_q.push_back(cyc);
            end
            prev_stall = lout.rev_v && !rev_ready;
            prev_held  = {lout.rev_v, lout.rev_data};
        end
    end

    function automatic fwd_pkt_t mk(input logic [1:0] op, input logic [11:0] addr, input logic [3:0] mask,
                                    input logic [31:0] data, input logic [4:0] rid);
        fwd_pkt_t p;
        p = '0;
        p.addr = addr; p.op = op; p.op_ex = mask; p.payload = data; p.reg_id = rid;
        p.src_x = rid[3:0]; p.src_y = ~rid[3:0];
        return p;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input fwd_pkt_t p);
        int n;
        n = 0;
        fwd_v = 1'b1;
        fwd_pkt = p;
        @(negedge clk);
        while (!lout.fwd_ready_and && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!lout.fwd_ready_and) begin
            checks++; errors++;
            $display("FAIL send_timeout: fwd.ready_and stayed %b, required 1", lout.fwd_ready_and);
        end
        @(posedge clk); #1;
        fwd_v = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_cnt < target && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (resp_cnt < target) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got %0d responses, required %0d", resp_cnt, target);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];

    initial begin
        int base, base_acc, base_resp;
        for (int i = 0; i < 1024; i++) mknown[i] = 4'h0;

        vecs[0] = '{OP_ST, 12'd5,    4'hF, 32'hA5A5_1234, 5'd3,  T_CREDIT, 32'h0,         16'd0};
        vecs[1] = '{OP_LD, 12'd5,    4'h0, 32'h0,         5'd3,  T_WB,     32'hA5A5_1234, 16'd0};
        vecs[2] = '{OP_ST, 12'd7,    4'hF, 32'hFFFF_FFFF, 5'd9,  T_CREDIT, 32'h0,         16'd0};
        vecs[3] = '{OP_ST, 12'd7,    4'h5, 32'h0000_0000, 5'd10, T_CREDIT, 32'h0,         16'd0};
        vecs[4] = '{OP_LD, 12'd7,    4'h0, 32'h0,         5'd11, T_WB,     32'hFF00_FF00, 16'd0};
        vecs[5] = '{OP_LD, 12'd1024, 4'h0, 32'h0,         5'd12, T_WB,     32'h0,         16'd1};
        vecs[6] = '{OP_ST, 12'd1029, 4'hF, 32'hDEAD_BEEF, 5'd13, T_CREDIT, 32'h0,         16'd2};
        vecs[7] = '{OP_LD, 12'd5,    4'h0, 32'h0,         5'd14, T_WB,     32'hA5A5_1234, 16'd2};
        vecs[8] = '{2'd2,  12'd5,    4'hF, 32'h1234_5678, 5'd15, T_CREDIT, 32'h0,         16'd2};
        vecs[9] = '{OP_LD, 12'd5,    4'h0, 32'h0,         5'd16, T_WB,     32'hA5A5_1234, 16'd2};

        // Reset state
        #1;
        check("rst_rev_v", lout.rev_v, 1'b0);
        check("rst_fwd_ready", lout.fwd_ready_and, 1'b0);
        check("rst_err_cnt", err_cnt, 16'd0);
        check("tied_fields", {lout.fwd_v, lout.rev_ready_and}, 2'b00);
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", lout.fwd_ready_and, 1'b1);

        // Directed vector table
        foreach (vecs[k]) begin
            base = resp_cnt;
            send(mk(vecs[k].op, vecs[k].addr, vecs[k].mask, vecs[k].data, vecs[k].reg_id));
            wait_resp(base + 1);
            check("vec_type", last_resp.pkt_type, vecs[k].exp_type);
            check("vec_data", last_resp.data, vecs[k].exp_data);
            check("vec_reg_id", last_resp.reg_id, vecs[k].reg_id);
            check("vec_dest", {last_resp.y_cord, last_resp.x_cord}, {~vecs[k].reg_id[3:0], vecs[k].reg_id[3:0]});
            check("vec_err_cnt", err_cnt, vecs[k].exp_err);
        end

        // Store then load to the same word, back-to-back
        base = resp_cnt;
        send(mk(OP_ST, 12'd6, 4'hF, 32'h0BAD_F00D, 5'd1));
        send(mk(OP_LD, 12'd6, 4'h0, 32'h0, 5'd2));
        wait_resp(base + 2);
        check("b2b_load_data", last_resp.data, 32'h0BAD_F00D);
        check("b2b_load_type", last_resp.pkt_type, T_WB);

        // Give every low word a known value for the later phases
        for (int i = 0; i < 16; i++) send(mk(OP_ST, 12'(i), 4'hF, $urandom, 5'(i)));
        wait_resp(resp_cnt + exp_q.size());

        // Backpressure: three requests fit, the fourth is held off
        @(posedge clk); #1;
        bp_mode = 1;
        base = resp_cnt;
        send(mk(OP_LD, 12'd5, 4'h0, 32'h0, 5'd20));
        send(mk(OP_LD, 12'd7, 4'h0, 32'h0, 5'd21));
        send(mk(OP_LD, 12'd6, 4'h0, 32'h0, 5'd22));
        fwd_v = 1'b1;
        fwd_pkt = mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd23);
        repeat (4) @(negedge clk);
        check("bp_fwd_ready", lout.fwd_ready_and, 1'b0);
        check("bp_rev_v", lout.rev_v, 1'b1);
        check("bp_no_resp", resp_cnt, base);
        @(posedge clk); #1;
        bp_mode = 0;
        send(mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd23));
        wait_resp(base + 4);
        repeat (5) begin @(posedge clk); #1; end
        check("bp_resp_count", resp_cnt, base + 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Streaming throughput and first-response latency
        base_acc = acc_cyc_q.size();
        base_resp = resp_cyc_q.size();
        for (int i = 0; i < 100; i++) send(mk(OP_LD, 12'($urandom_range(0, 15)), 4'h0, 32'h0, 5'($urandom)));
        wait_resp(resp_cnt + exp_q.size());
        if (resp_cyc_q.size() >= base_resp + 100 && acc_cyc_q.size() >= base_acc + 100) begin
            check("stream_latency", resp_cyc_q[base_resp] - acc_cyc_q[base_acc], 2);
            check("stream_acc_span", acc_cyc_q[base_acc + 99] - acc_cyc_q[base_acc], 99);
            check("stream_resp_span", resp_cyc_q[base_resp + 99] - resp_cyc_q[base_resp], 99);
        end else begin
            checks++; errors++;
            $display("FAIL stream_count: got %0d responses, required %0d",
                     resp_cyc_q.size() - base_resp, 100);
        end

        // Randomized traffic with random backpressure
        bp_mode = 2;
        base = resp_cnt;
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [11:0] a;
            logic [1:0] op;
            r = $urandom_range(0, 7);
            a = ($urandom_range(0, 7) == 0) ? 12'(1024 + $urandom_range(0, 3071)) : 12'($urandom_range(0, 15));
            op = (r < 3) ? OP_LD : (r < 6) ? OP_ST : 2'($urandom_range(2, 3));
            send(mk(op, a, 4'($urandom), $urandom, 5'($urandom)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bp_mode = 0;
        wait_resp(base + 300);
        repeat (3) begin @(posedge clk); #1; end
        check("rand_err_cnt", err_cnt, model_err);
        check("rand_resp_count", resp_cnt, base + 300);

        // Reset with FIFO full and a response pending
        send(mk(OP_ST, 12'd9, 4'hF, 32'h5EED_CAFE, 5'd4));
        wait_resp(resp_cnt + exp_q.size());
        @(posedge clk); #1;
        bp_mode = 1;
        send(mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd5));
        send(mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd6));
        send(mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd7));
        fwd_v = 1'b1;
        fwd_pkt = mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd8);
        repeat (2) @(negedge clk);
        check("pre_rst_full", lout.fwd_ready_and, 1'b0);
        check("pre_rst_rev_v", lout.rev_v, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        fwd_v = 1'b0;
        exp_q.delete();
        model_err = '0;
        #1;
        check("mid_rst_rev_v", lout.rev_v, 1'b0);
        check("mid_rst_fwd_ready", lout.fwd_ready_and, 1'b0);
        check("mid_rst_err_cnt", err_cnt, 16'd0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;
        bp_mode = 0;
        base = resp_cnt;
        repeat (6) begin @(posedge clk); #1; end
        check("post_rst_no_resp", resp_cnt, base);
        send(mk(OP_LD, 12'd9, 4'h0, 32'h0, 5'd30));
        wait_resp(base + 1);
        check("post_rst_data", last_resp.data, 32'h5EED_CAFE);
        check("post_rst_err_cnt", err_cnt, 16'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
